// File: rtl/stream_switch_pkt_arbiter.sv
// stream_switch_pkt_arbiter: packet-atomic round-robin merge of NUM_IN AXI-Stream inputs
// Optional output skid buffer enabled by defining STREAM_SWITCH_ARB_OUT_REG_EN.
module stream_switch_pkt_arbiter #(
  parameter int NUM_IN = 2
) (
  input  logic                      axis_aclk,
  input  logic                      axis_rst,
  input  logic [NUM_IN-1:0]         s_axis_tvalid,
  input  logic [512*NUM_IN-1:0]     s_axis_tdata,
  input  logic [64*NUM_IN-1:0]      s_axis_tkeep,
  input  logic [NUM_IN-1:0]         s_axis_tlast,
  input  logic [16*NUM_IN-1:0]      s_axis_tuser_size,
  input  logic [16*NUM_IN-1:0]      s_axis_tuser_src,
  input  logic [16*NUM_IN-1:0]      s_axis_tuser_dst,
  output logic [NUM_IN-1:0]         s_axis_tready,
  output logic                      m_axis_tvalid,
  output logic [511:0]              m_axis_tdata,
  output logic [63:0]               m_axis_tkeep,
  output logic                      m_axis_tlast,
  output logic [15:0]               m_axis_tuser_size,
  output logic [15:0]               m_axis_tuser_src,
  output logic [15:0]               m_axis_tuser_dst,
  input  logic                      m_axis_tready,
  output logic [$clog2(NUM_IN)-1:0] grant_id,
  output logic                      busy,
  output logic [32*NUM_IN-1:0]      pkt_cnt
);
  localparam int GW = $clog2(NUM_IN);
  typedef enum logic {IDLE, BUSY} state_t;
  typedef struct packed {
    logic [511:0] data;
    logic [63:0]  keep;
    logic         last;
    logic [15:0]  size;
    logic [15:0]  src;
    logic [15:0]  dst;
  } beat_t;
  state_t              state_q, state_d;
  logic [GW-1:0]       grant_q, grant_d, last_q, last_d;
  logic [32*NUM_IN-1:0] pkt_cnt_q, pkt_cnt_d;
  logic [NUM_IN-1:0]   oth;
  logic                a_valid, a_ready, eop;
  beat_t               a_beat;
  // Round-robin pick: first requester after 'from', wrapping; descending scan lets the nearest win.
  function automatic logic [GW-1:0] rr(input logic [GW-1:0] from, input logic [NUM_IN-1:0] req);
    int idx;
    rr = from;
    for (int k = NUM_IN; k >= 1; k--) begin
      idx = (int'(from) + k) % NUM_IN;
      if (req[idx]) rr = GW'(idx);
    end
  endfunction
  // Mux the granted input onto the arbiter-side stream and route its ready back.
  always_comb begin
    a_valid = 1'b0;
    a_beat = '0;
    s_axis_tready = '0;
    if (state_q == BUSY) begin
      a_valid = s_axis_tvalid[grant_q];
      a_beat.data = s_axis_tdata[512*int'(grant_q) +: 512];
      a_beat.keep = s_axis_tkeep[64*int'(grant_q) +: 64];
      a_beat.last = s_axis_tlast[grant_q];
      a_beat.size = s_axis_tuser_size[16*int'(grant_q) +: 16];
      a_beat.src = s_axis_tuser_src[16*int'(grant_q) +: 16];
      a_beat.dst = s_axis_tuser_dst[16*int'(grant_q) +: 16];
      s_axis_tready[grant_q] = a_ready;
    end
  end
  // Grant FSM: arbitrate from IDLE, hold through tlast, hand over without a bubble when others wait.
  always_comb begin
    eop = (state_q == BUSY) && a_valid && a_ready && a_beat.last;
    oth = s_axis_tvalid;
    oth[grant_q] = 1'b0;
    state_d = state_q;
    grant_d = grant_q;
    last_d = last_q;
    pkt_cnt_d = pkt_cnt_q;
    if (state_q == IDLE) begin
      state_d = |s_axis_tvalid ? BUSY : IDLE;
      grant_d = |s_axis_tvalid ? rr(last_q, s_axis_tvalid) : grant_q;
    end else if (eop) begin
      last_d = grant_q;
      state_d = |oth ? BUSY : IDLE;
      grant_d = |oth ? rr(grant_q, oth) : grant_q;
      pkt_cnt_d[32*int'(grant_q) +: 32] = pkt_cnt_q[32*int'(grant_q) +: 32] + 32'd1;
    end
  end
  // State, grant and round-robin pointer registers.
  always_ff @(posedge axis_aclk or posedge axis_rst) begin
    if (axis_rst) begin
      state_q <= IDLE;
      grant_q <= '0;
      last_q <= GW'(NUM_IN - 1);
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q <= last_d;
    end
  end
  // Packet counters move only on a completed tlast handshake.
  always_ff @(posedge axis_aclk or posedge axis_rst) begin
    if (axis_rst) pkt_cnt_q <= '0;
    else if (eop) pkt_cnt_q <= pkt_cnt_d;
  end
  assign grant_id = grant_q;
  assign busy = (state_q == BUSY);
  assign pkt_cnt = pkt_cnt_q;
`ifdef STREAM_SWITCH_ARB_OUT_REG_EN
  beat_t      mem_q [2];
  logic       wp_q, rp_q, push, pop;
  logic [1:0] cnt_q;
  beat_t      o_beat;
  // Two-entry buffer: ready toward the arbiter depends only on occupancy, so it is a registered signal.
  always_comb begin
    a_ready = (cnt_q != 2'd2);
    push = a_valid && a_ready;
    m_axis_tvalid = (cnt_q != 2'd0);
    pop = m_axis_tvalid && m_axis_tready;
    o_beat = mem_q[rp_q];
    m_axis_tdata = o_beat.data;
    m_axis_tkeep = o_beat.keep;
    m_axis_tlast = o_beat.last;
    m_axis_tuser_size = o_beat.size;
    m_axis_tuser_src = o_beat.src;
    m_axis_tuser_dst = o_beat.dst;
  end
  // Buffer storage and pointers; cleared on reset so outputs read zero.
  always_ff @(posedge axis_aclk or posedge axis_rst) begin
    if (axis_rst) begin
      mem_q <= '{default: '0};
      wp_q <= 1'b0;
      rp_q <= 1'b0;
      cnt_q <= 2'd0;
    end else begin
      if (push) mem_q[wp_q] <= a_beat;
      wp_q <= wp_q ^ push;
      rp_q <= rp_q ^ pop;
      cnt_q <= cnt_q + 2'(push) - 2'(pop);
    end
  end
`else
  // Combinational output: downstream ready flows straight back to the granted input.
  always_comb begin
    a_ready = m_axis_tready;
    m_axis_tvalid = a_valid;
    m_axis_tdata = a_beat.data;
    m_axis_tkeep = a_beat.keep;
    m_axis_tlast = a_beat.last;
    m_axis_tuser_size = a_beat.size;
    m_axis_tuser_src = a_beat.src;
    m_axis_tuser_dst = a_beat.dst;
  end
`endif
endmodule

// File: tb/tb_stream_switch_pkt_arbiter.sv
// tb_stream_switch_pkt_arbiter: directed checks of grant, packet atomicity, counters and reset
module tb_stream_switch_pkt_arbiter;
  localparam int N = 2;
  logic           clk = 1'b0, rst = 1'b1;
  logic [N-1:0]   s_tvalid, s_tlast, s_tready;
  logic [512*N-1:0] s_tdata;
  logic [64*N-1:0]  s_tkeep;
  logic [16*N-1:0]  s_size, s_src, s_dst;
  logic           m_tvalid, m_tlast, m_tready;
  logic [511:0]   m_tdata;
  logic [63:0]    m_tkeep;
  logic [15:0]    m_size, m_src, m_dst;
  logic [0:0]     grant;
  logic           busy;
  logic [32*N-1:0] cnt;
  int beat [N], pkt [N], npkt [N], len [N];
  int n_cmp = 0, n_err = 0, t;
  stream_switch_pkt_arbiter #(.NUM_IN(N)) dut (
    .axis_aclk(clk), .axis_rst(rst),
    .s_axis_tvalid(s_tvalid), .s_axis_tdata(s_tdata), .s_axis_tkeep(s_tkeep), .s_axis_tlast(s_tlast),
    .s_axis_tuser_size(s_size), .s_axis_tuser_src(s_src), .s_axis_tuser_dst(s_dst),
    .s_axis_tready(s_tready),
    .m_axis_tvalid(m_tvalid), .m_axis_tdata(m_tdata), .m_axis_tkeep(m_tkeep), .m_axis_tlast(m_tlast),
    .m_axis_tuser_size(m_size), .m_axis_tuser_src(m_src), .m_axis_tuser_dst(m_dst),
    .m_axis_tready(m_tready), .grant_id(grant), .busy(busy), .pkt_cnt(cnt)
  );
  always #5 clk = ~clk;
  function automatic logic [511:0] exp_d(input int i, input int p, input int b);
    logic [511:0] d;
    d = 512'({8'(i), 8'(p), 8'(b)});
    d[511:496] = 16'hA500 | 16'(i);
    return d;
  endfunction
  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic drive();
    for (int i = 0; i < N; i++) begin
      s_tvalid[i] = pkt[i] < npkt[i];
      s_tlast[i] = s_tvalid[i] && (beat[i] == len[i] - 1);
      s_tdata[512*i +: 512] = exp_d(i, pkt[i], beat[i]);
      s_tkeep[64*i +: 64] = ~64'(beat[i]);
      s_size[16*i +: 16] = 16'(len[i] * 64);
      s_src[16*i +: 16] = 16'(i);
      s_dst[16*i +: 16] = 16'(pkt[i] * 16 + beat[i]);
    end
  endtask
  task automatic cyc();
    logic [N-1:0] hs;
    hs = s_tvalid & s_tready;
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++)
      if (hs[i]) begin
        if (beat[i] == len[i] - 1) begin
          beat[i] = 0;
          pkt[i]++;
        end else beat[i]++;
      end
    drive();
    @(negedge clk);
  endtask
  task automatic clear_src();
    for (int i = 0; i < N; i++) begin
      beat[i] = 0;
      pkt[i] = 0;
      npkt[i] = 0;
      len[i] = 1;
    end
    drive();
  endtask
  task automatic do_reset();
    rst = 1'b1;
    m_tready = 1'b1;
    clear_src();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask
  initial begin
    m_tready = 1'b1;
    clear_src();
    @(negedge clk);
    chk("rst_tvalid", 512'(m_tvalid), 512'd0);
    chk("rst_tready", 512'(s_tready), 512'd0);
    chk("rst_busy", 512'(busy), 512'd0);
    chk("rst_grant", 512'(grant), 512'd0);
    chk("rst_cnt", 512'(cnt), 512'd0);
    chk("rst_tdata", m_tdata, 512'd0);
    rst = 1'b0;
    len[1] = 3;
    npkt[1] = 1;
    drive();
    #1;
    chk("single_latency", 512'(m_tvalid), 512'd0);
    cyc();
    for (int b = 0; b < 3; b++) begin
      chk("single_tvalid", 512'(m_tvalid), 512'd1);
      chk("single_grant", 512'(grant), 512'd1);
      chk("single_data", m_tdata, exp_d(1, 0, b));
      chk("single_user", 512'({m_size, m_src, m_dst}), 512'({16'd192, 16'd1, 16'(b)}));
      chk("single_last", 512'(m_tlast), 512'(b == 2));
      chk("single_tready", 512'(s_tready), 512'b10);
      cyc();
    end
    chk("single_cnt", 512'(cnt), 512'({32'd1, 32'd0}));
    chk("single_busy", 512'(busy), 512'd0);
    chk("single_idle", 512'(m_tvalid), 512'd0);
    do_reset();
    len[0] = 2;
    len[1] = 2;
    npkt[0] = 4;
    npkt[1] = 4;
    drive();
    #1;
    chk("cont_latency", 512'(m_tvalid), 512'd0);
    cyc();
    for (int k = 0; k < 16; k++) begin
      chk("cont_tvalid", 512'(m_tvalid), 512'd1);
      chk("cont_grant", 512'(grant), 512'((k / 2) % 2));
      chk("cont_data", m_tdata, exp_d((k / 2) % 2, k / 4, k % 2));
      cyc();
    end
    chk("cont_cnt", 512'(cnt), 512'({32'd4, 32'd4}));
    chk("cont_busy", 512'(busy), 512'd0);
    force dut.pkt_cnt_q = {32'd4, 32'hFFFF_FFFF};
    @(negedge clk);
    release dut.pkt_cnt_q;
    #1;
    chk("wrap_preset", 512'(cnt), 512'({32'd4, 32'hFFFF_FFFF}));
    len[0] = 1;
    npkt[0] = 5;
    drive();
    cyc();
    chk("wrap_grant", 512'(grant), 512'd0);
    chk("wrap_data", m_tdata, exp_d(0, 4, 0));
    chk("wrap_last", 512'(m_tlast), 512'd1);
    cyc();
    chk("wrap_cnt", 512'(cnt), 512'({32'd4, 32'd0}));
    chk("wrap_busy", 512'(busy), 512'd0);
    len[1] = 4;
    npkt[1] = 5;
    npkt[0] = 6;
    drive();
    cyc();
    t = 0;
    while (pkt[1] < 5 && t < 20) begin
      m_tready = (t % 2) == 0;
      #1;
      chk("bp_grant", 512'(grant), 512'd1);
      chk("bp_tready", 512'(s_tready), 512'({m_tready, 1'b0}));
      chk("bp_tvalid", 512'(m_tvalid), 512'd1);
      chk("bp_data", m_tdata, exp_d(1, 4, beat[1]));
      cyc();
      t++;
    end
    chk("bp_cycles", 512'(t), 512'd7);
    m_tready = 1'b1;
    #1;
    chk("bp_handover_grant", 512'(grant), 512'd0);
    chk("bp_handover_valid", 512'(m_tvalid), 512'd1);
    chk("bp_handover_data", m_tdata, exp_d(0, 5, 0));
    cyc();
    chk("bp_cnt", 512'(cnt), 512'({32'd5, 32'd1}));
    chk("bp_busy", 512'(busy), 512'd0);
    len[0] = 5;
    npkt[0] = 7;
    drive();
    cyc();
    for (int b = 0; b < 2; b++) begin
      chk("mid_data", m_tdata, exp_d(0, 6, b));
      cyc();
    end
    chk("mid_beat2", m_tdata, exp_d(0, 6, 2));
    rst = 1'b1;
    #1;
    chk("mid_rst_tvalid", 512'(m_tvalid), 512'd0);
    chk("mid_rst_tready", 512'(s_tready), 512'd0);
    chk("mid_rst_busy", 512'(busy), 512'd0);
    chk("mid_rst_grant", 512'(grant), 512'd0);
    chk("mid_rst_cnt", 512'(cnt), 512'd0);
    chk("mid_rst_tdata", m_tdata, 512'd0);
    @(negedge clk);
    rst = 1'b0;
    beat[0] = 0;
    drive();
    cyc();
    for (int b = 0; b < 5; b++) begin
      chk("resend_grant", 512'(grant), 512'd0);
      chk("resend_data", m_tdata, exp_d(0, 6, b));
      cyc();
    end
    chk("resend_cnt", 512'(cnt), 512'({32'd0, 32'd1}));
    chk("resend_busy", 512'(busy), 512'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
